// File: rtl/vadd_engine.sv
// rtl/vadd_engine.sv - element-wise vector adder driving one BRAM port (read A, read B, write A+B)
module vadd_engine #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_a_addr,
  input  logic [ADDR_WIDTH-1:0] src_b_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [31:0]           len,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  comp_en_b,
  output logic                  comp_we_b,
  output logic [ADDR_WIDTH-1:0] comp_addr_b,
  output logic [DATA_WIDTH-1:0] comp_din_b,
  input  logic [DATA_WIDTH-1:0] comp_dout_b
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WAIT, WR, DONE} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] src_a_q, src_b_q, dst_q;
  logic [31:0]           len_q;
  logic [31:0]           idx;
  logic [1:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] op_a;
  logic                  accept;
  logic                  wait_last;
  logic [DATA_WIDTH:0]   sum;
  logic [ADDR_WIDTH-1:0] idx_addr;

  // busy also covers the cycle after DONE, so a new command waits for done to drop
  assign accept    = (state == IDLE) && start && !busy;
  assign wait_last = (wait_cnt == 2'(RD_LAT - 1));
  assign sum       = {1'b0, op_a} + {1'b0, comp_dout_b};
  assign idx_addr  = idx[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (len == 32'd0) ? DONE : RD_A;
      RD_A: state_nx = RD_B;
      RD_B: state_nx = WAIT;
      WAIT: if (wait_last) state_nx = WR;
      WR:   state_nx = (idx + 32'd1 < len_q) ? RD_A : DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      op_a     <= '0;
    end else begin
      if (accept) begin
        src_a_q <= src_a_addr;
        src_b_q <= src_b_addr;
        dst_q   <= dst_addr;
        len_q   <= len;
        idx     <= '0;
      end else if (state == WR) begin
        idx <= idx + 32'd1;
      end
      if (state == RD_B)      wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 2'd1;
      // A arrives on the last WAIT edge; B is consumed directly from dout in WR
      if (state == WAIT && wait_last) op_a <= comp_dout_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      comp_en_b   <= 1'b0;
      comp_we_b   <= 1'b0;
      comp_addr_b <= '0;
      comp_din_b  <= '0;
    end else begin
      comp_en_b <= 1'b0;
      comp_we_b <= 1'b0;
      done      <= (state == DONE);
      busy      <= (state_nx != IDLE) || (state == DONE);
      if (accept)                        ovf <= 1'b0;
      else if (state == WR && sum[DATA_WIDTH]) ovf <= 1'b1;
      case (state)
        RD_A: begin
          comp_en_b   <= 1'b1;
          comp_addr_b <= src_a_q + idx_addr;
        end
        RD_B: begin
          comp_en_b   <= 1'b1;
          comp_addr_b <= src_b_q + idx_addr;
        end
        WR: begin
          comp_en_b   <= 1'b1;
          comp_we_b   <= 1'b1;
          comp_addr_b <= dst_q + idx_addr;
          comp_din_b  <= sum[DATA_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vadd_engine.sv
// tb/tb_vadd_engine.sv - scoreboard bench for vadd_engine with RD_LAT=1 and RD_LAT=2 instances
module tb_vadd_engine;
  localparam int AW = 13;
  localparam int DW = 32;

  typedef struct {
    int            k;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xact_t;

  typedef struct {
    int   k;
    int   cyc;
    logic ovf;
  } dn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start_s [2];
  logic [AW-1:0] sa_s [2], sb_s [2], dst_s [2];
  logic [31:0]   len_s [2];
  logic          busy_s [2], done_s [2], ovf_s [2], en_s [2], we_s [2];
  logic [AW-1:0] addr_s [2];
  logic [DW-1:0] din_s [2], dout_s [2], d1 [2], d2 [2];

  logic [DW-1:0] mem     [2][8192];
  logic [DW-1:0] ref_mem [2][8192];

  logic          pl_en;
  int            pl_k;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  xact_t exp_x [$];
  dn_t   exp_d [$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    vadd_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(g + 1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_s[g]),
      .src_a_addr (sa_s[g]),
      .src_b_addr (sb_s[g]),
      .dst_addr   (dst_s[g]),
      .len        (len_s[g]),
      .busy       (busy_s[g]),
      .done       (done_s[g]),
      .ovf        (ovf_s[g]),
      .comp_en_b  (en_s[g]),
      .comp_we_b  (we_s[g]),
      .comp_addr_b(addr_s[g]),
      .comp_din_b (din_s[g]),
      .comp_dout_b(dout_s[g])
    );
  end

  assign dout_s[0] = d1[0];
  assign dout_s[1] = d2[1];

  always @(posedge clk) cyc <= cyc + 1;

  // read-first BRAM models, one per instance, plus a backdoor preload port
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (en_s[k]) begin
        d1[k] <= mem[k][addr_s[k]];
        if (we_s[k]) mem[k][addr_s[k]] <= din_s[k];
      end
      d2[k] <= d1[k];
    end
    if (pl_en) mem[pl_k][pl_addr] <= pl_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    xact_t e;
    dn_t   dd;
    for (int k = 0; k < 2; k++) begin
      if (en_s[k] === 1'b1) begin
        if (exp_x.size() == 0) begin
          chk("bram_access_unexpected", 64'(addr_s[k]) | 64'h1_0000_0000, 64'h0);
        end else begin
          e = exp_x.pop_front();
          chk("acc_inst", 64'(k), 64'(e.k));
          chk("acc_we", 64'(we_s[k]), 64'(e.we));
          chk("acc_addr", 64'(addr_s[k]), 64'(e.addr));
          if (e.we) chk("wr_data", 64'(din_s[k]), 64'(e.data));
        end
      end
      if (done_s[k] === 1'b1) begin
        if (exp_d.size() == 0) begin
          chk("done_unexpected", 64'(k + 1), 64'h0);
        end else begin
          dd = exp_d.pop_front();
          chk("done_inst", 64'(k), 64'(dd.k));
          chk("done_cycle", 64'(cyc), 64'(dd.cyc));
          chk("done_ovf", 64'(ovf_s[k]), 64'(dd.ovf));
        end
      end
    end
  end

  task automatic preload(input int k, input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_k = k; pl_addr = a; pl_data = v;
    ref_mem[k][a] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // reference: element j reads A[j], B[j] then writes their sum, strictly in order
  task automatic model(input int k, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                       input logic [AW-1:0] d, input int n, input int n_full, output logic ov);
    logic [DW:0]   s;
    logic [AW-1:0] ja, jb, jd;
    ov = 1'b0;
    for (int j = 0; j < n; j++) begin
      ja = sa + AW'(j);
      jb = sb + AW'(j);
      jd = d + AW'(j);
      s = {1'b0, ref_mem[k][ja]} + {1'b0, ref_mem[k][jb]};
      exp_x.push_back('{k: k, we: 1'b0, addr: ja, data: '0});
      exp_x.push_back('{k: k, we: 1'b0, addr: jb, data: '0});
      if (j < n_full) begin
        if (s[DW]) ov = 1'b1;
        ref_mem[k][jd] = s[DW-1:0];
        exp_x.push_back('{k: k, we: 1'b1, addr: jd, data: s[DW-1:0]});
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((exp_x.size() != 0 || exp_d.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("pending_at_timeout", 64'(exp_x.size() + exp_d.size()), 64'h0);
    exp_x.delete();
    exp_d.delete();
  endtask

  task automatic chk_reset(input int k);
    chk("rst_busy", 64'(busy_s[k]), 64'h0);
    chk("rst_done", 64'(done_s[k]), 64'h0);
    chk("rst_ovf", 64'(ovf_s[k]), 64'h0);
    chk("rst_en", 64'(en_s[k]), 64'h0);
    chk("rst_we", 64'(we_s[k]), 64'h0);
    chk("rst_addr", 64'(addr_s[k]), 64'h0);
    chk("rst_din", 64'(din_s[k]), 64'h0);
  endtask

  task automatic run_cmd(input int k, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                         input logic [AW-1:0] d, input int n, input bit rel_rst);
    logic ov;
    int   acc;
    model(k, sa, sb, d, n, n, ov);
    @(negedge clk);
    if (rel_rst) rst_n = 1'b1;
    start_s[k] = 1'b1; sa_s[k] = sa; sb_s[k] = sb; dst_s[k] = d; len_s[k] = 32'(n);
    acc = cyc + 1;
    exp_d.push_back('{k: k, cyc: acc + (3 + k + 1) * n + 1, ovf: ov});
    @(negedge clk);
    start_s[k] = 1'b0;
    chk("busy_after_accept", 64'(busy_s[k]), 64'h1);
    chk("ovf_clear_on_accept", 64'(ovf_s[k]), 64'h0);
    wait_drain(400);
    repeat (2) @(negedge clk);
    chk("ovf_held_after_done", 64'(ovf_s[k]), 64'(ov));
    chk("busy_after_done", 64'(busy_s[k]), 64'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t reached limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic          ov;
    int            acc, k, n;
    logic [AW-1:0] sa, sb, d;
    logic [DW-1:0] v;

    rst_n = 1'b0;
    pl_en = 1'b0; pl_k = 0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; sa_s[i] = '0; sb_s[i] = '0; dst_s[i] = '0; len_s[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);

    // basic vector, accepted on the very first edge after reset release
    for (int j = 0; j < 4; j++) begin
      preload(0, AW'(j), DW'(j + 1));
      preload(0, AW'(16 + j), DW'(10 * (j + 1)));
    end
    run_cmd(0, 13'd0, 13'd16, 13'd32, 4, 1'b1);
    chk("vec_result_35", 64'(ref_mem[0][35]), 64'd44);

    // carry-out: ovf sticky after done, cleared by the next command
    preload(0, 13'd50, 32'hFFFF_FFFF);
    preload(0, 13'd60, 32'd2);
    run_cmd(0, 13'd50, 13'd60, 13'd70, 1, 1'b0);
    chk("carry_result", 64'(ref_mem[0][70]), 64'h1);

    run_cmd(0, 13'd5, 13'd6, 13'd7, 0, 1'b0);

    // address wrap with the two-cycle-latency instance
    preload(1, 13'h1FFF, 32'd7);
    preload(1, 13'h0000, 32'd9);
    preload(1, 13'd200, 32'd100);
    preload(1, 13'd201, 32'd200);
    run_cmd(1, 13'h1FFF, 13'd200, 13'd300, 2, 1'b0);

    // in place, then a chained overlap where each result feeds the next read
    preload(0, 13'd100, 32'd5);
    preload(0, 13'd101, 32'd6);
    preload(0, 13'd110, 32'd1);
    preload(0, 13'd111, 32'd1);
    run_cmd(0, 13'd100, 13'd110, 13'd100, 2, 1'b0);
    chk("inplace_0", 64'(ref_mem[0][100]), 64'd6);
    chk("inplace_1", 64'(ref_mem[0][101]), 64'd7);
    for (int j = 0; j < 4; j++) begin
      preload(1, AW'(120 + j), DW'(j + 3));
      preload(1, AW'(130 + j), DW'(100));
    end
    run_cmd(1, 13'd120, 13'd130, 13'd121, 3, 1'b0);

    for (int it = 0; it < 10; it++) begin
      k  = int'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 5));
      sa = AW'($urandom_range(0, 8191));
      sb = AW'($urandom_range(0, 8191));
      d  = AW'($urandom_range(0, 8191));
      for (int j = 0; j < n; j++) begin
        v = $urandom;
        if ($urandom_range(0, 2) == 0) v[31:28] = 4'hF;
        preload(k, sa + AW'(j), v);
        v = $urandom;
        if ($urandom_range(0, 2) == 0) v[31:28] = 4'hF;
        preload(k, sb + AW'(j), v);
      end
      run_cmd(k, sa, sb, d, n, 1'b0);
    end

    // abort: ignored second start, then reset during the second element's WAIT
    for (int j = 0; j < 8; j++) begin
      preload(0, AW'(300 + j), $urandom);
      preload(0, AW'(400 + j), $urandom);
    end
    model(0, 13'd300, 13'd400, 13'd500, 2, 1, ov);
    @(negedge clk);
    start_s[0] = 1'b1; sa_s[0] = 13'd300; sb_s[0] = 13'd400; dst_s[0] = 13'd500; len_s[0] = 32'd8;
    acc = cyc + 1;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b1; sa_s[0] = 13'd1000; sb_s[0] = 13'd1100; dst_s[0] = 13'd1200; len_s[0] = 32'd3;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int t = 0; t < 50 && cyc != acc + 6; t++) @(negedge clk);
    chk("abort_point_reached", 64'(cyc), 64'(acc + 6));
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    chk("abort_reads_seen", 64'(exp_x.size()), 64'h0);
    exp_x.delete();
    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      preload(0, AW'(1300 + j), $urandom);
      preload(0, AW'(1400 + j), $urandom);
    end
    run_cmd(0, 13'd1300, 13'd1400, 13'd1500, 3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
